logo_motion_scheduler: RTL and testbench



---
 rtl/logo_pkg.sv | 31 +++
 rtl/logo_motion_scheduler_if.sv | 38 +++
 rtl/logo_axis_stepper.sv | 66 ++++++
 rtl/logo_motion_scheduler.sv | 164 ++++++++++++++++
 tb/tb_logo_motion_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/logo_pkg.sv
// logo_pkg: shared types and constants for the bouncing-logo motion path.
//   mode_e             - control mode encodings (AUTO/MANUAL/PAUSED)
//   *_DEFAULT          - default logo and display geometry
//   edge_limit()       - largest legal logo origin along one axis
//   SPEED_MIN/MAX      - bounce speed range in pixels per frame
package logo_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_PAUSED = 2'd2
    } mode_e;

    localparam int unsigned LOGO_SIZE_DEFAULT      = 128;
    localparam int unsigned DISPLAY_WIDTH_DEFAULT  = 640;
    localparam int unsigned DISPLAY_HEIGHT_DEFAULT = 480;

    function automatic logic [9:0] edge_limit(input int unsigned extent,
                                              input int unsigned size);
        return 10'(extent - size);
    endfunction

    localparam logic [9:0] MAX_X_DEFAULT =
        edge_limit(DISPLAY_WIDTH_DEFAULT, LOGO_SIZE_DEFAULT);
    localparam logic [9:0] MAX_Y_DEFAULT =
        edge_limit(DISPLAY_HEIGHT_DEFAULT, LOGO_SIZE_DEFAULT);

    localparam logic [2:0] SPEED_MIN = 3'd1;
    localparam logic [2:0] SPEED_MAX = 3'd7;

endpackage

// File: rtl/logo_motion_scheduler_if.sv
// logo_motion_scheduler_if: bundle between sync generator / gamepad decoder
// and the pixel datapath.
//   vpos, btn_*            - line counter and decoded gamepad levels (inputs)
//   logo_left, logo_top    - logo origin (outputs)
//   color_index, mode      - palette index and control mode (outputs)
//   frame_tick, corner_hit - single-cycle event pulses (outputs)
// modport master: the scheduler; modport slave: its environment.
interface logo_motion_scheduler_if;

    logic [9:0] vpos;
    logic       btn_start;
    logic       btn_select;
    logic       btn_a;
    logic       btn_b;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [9:0] logo_left;
    logic [9:0] logo_top;
    logic [2:0] color_index;
    logic [1:0] mode;
    logic       frame_tick;
    logic       corner_hit;

    modport master (
        input  vpos, btn_start, btn_select, btn_a, btn_b,
               btn_up, btn_down, btn_left, btn_right,
        output logo_left, logo_top, color_index, mode, frame_tick, corner_hit
    );

    modport slave (
        output vpos, btn_start, btn_select, btn_a, btn_b,
               btn_up, btn_down, btn_left, btn_right,
        input  logo_left, logo_top, color_index, mode, frame_tick, corner_hit
    );

endinterface

// File: rtl/logo_axis_stepper.sv
// logo_axis_stepper: combinational next position/direction for one axis.
//   pos, dir          - current origin and direction (1 = increasing)
//   step              - AUTO speed in pixels
//   max               - largest legal origin
//   override_neg/pos  - direction buttons (left/up, right/down)
//   auto_en/manual_en - current mode
//   next_pos/next_dir - values to load on the frame tick
//   bounce            - axis hit an edge this step (AUTO only)
module logo_axis_stepper (
    input  logic [9:0] pos,
    input  logic       dir,
    input  logic [2:0] step,
    input  logic [9:0] max,
    input  logic       override_neg,
    input  logic       override_pos,
    input  logic       auto_en,
    input  logic       manual_en,
    output logic [9:0] next_pos,
    output logic       next_dir,
    output logic       bounce
);

    logic        eff_dir;
    logic [10:0] sum;

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        bounce   = 1'b0;
        eff_dir  = dir;
        sum      = 11'(pos) + 11'(step);
        if (auto_en) begin
            // Override picks the direction first; the step then uses it.
            if (override_neg) begin
                eff_dir = 1'b0;
            end else if (override_pos) begin
                eff_dir = 1'b1;
            end
            next_dir = eff_dir;
            if (eff_dir) begin
                if (sum >= 11'(max)) begin
                    next_pos = max;
                    next_dir = 1'b0;
                    bounce   = 1'b1;
                end else begin
                    next_pos = sum[9:0];
                end
            end else begin
                if (11'(pos) <= 11'(step)) begin
                    next_pos = '0;
                    next_dir = 1'b1;
                    bounce   = 1'b1;
                end else begin
                    next_pos = pos - 10'(step);
                end
            end
        end else if (manual_en) begin
            if (override_neg && !override_pos) begin
                next_pos = (pos == '0) ? '0 : pos - 10'd1;
            end else if (override_pos && !override_neg) begin
                next_pos = (pos >= max) ? max : pos + 10'd1;
            end
        end
    end

endmodule

// File: rtl/logo_motion_scheduler.sv
// logo_motion_scheduler: once per frame updates logo position, colour and
// control mode (AUTO/MANUAL/PAUSED) from gamepad edges and bounce logic.
//   clk   - pixel clock
//   rst_n - asynchronous active-low reset
//   bus   - logo_motion_scheduler_if.master (vpos/buttons in, logo state out)
module logo_motion_scheduler
    import logo_pkg::*;
#(
    parameter int unsigned LOGO_SIZE      = LOGO_SIZE_DEFAULT,
    parameter int unsigned DISPLAY_WIDTH  = DISPLAY_WIDTH_DEFAULT,
    parameter int unsigned DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEFAULT,
    parameter int unsigned START_X        = 200,
    parameter int unsigned START_Y        = 200
) (
    input logic                    clk,
    input logic                    rst_n,
    logo_motion_scheduler_if.master bus
);

    localparam logic [9:0] MAX_X = edge_limit(DISPLAY_WIDTH, LOGO_SIZE);
    localparam logic [9:0] MAX_Y = edge_limit(DISPLAY_HEIGHT, LOGO_SIZE);

    logic [9:0] prev_vpos;
    logic       frame_tick;
    logic [3:0] btn_prev;
    logic [3:0] btn_now;
    logic [3:0] btn_edge;
    logic       start_edge, select_edge, a_edge, b_edge;

    mode_e      mode_q, mode_d, resume_q, resume_d;
    logic [2:0] speed_q;
    logic       dir_x_q, dir_y_q;
    logic [9:0] left_q, top_q;
    logic [2:0] color_q;
    logic       corner_q;

    logic [9:0] next_x, next_y;
    logic       next_dir_x, next_dir_y;
    logic       bounce_x, bounce_y;
    logic       auto_en, manual_en;

    assign btn_now     = {bus.btn_start, bus.btn_select, bus.btn_a, bus.btn_b};
    assign btn_edge    = btn_now & ~btn_prev;
    assign start_edge  = btn_edge[3];
    assign select_edge = btn_edge[2];
    assign a_edge      = btn_edge[1];
    assign b_edge      = btn_edge[0];
    assign auto_en     = (mode_q == MODE_AUTO);
    assign manual_en   = (mode_q == MODE_MANUAL);

    logo_axis_stepper u_step_x (
        .pos         (left_q),
        .dir         (dir_x_q),
        .step        (speed_q),
        .max         (MAX_X),
        .override_neg(bus.btn_left),
        .override_pos(bus.btn_right),
        .auto_en     (auto_en),
        .manual_en   (manual_en),
        .next_pos    (next_x),
        .next_dir    (next_dir_x),
        .bounce      (bounce_x)
    );

    logo_axis_stepper u_step_y (
        .pos         (top_q),
        .dir         (dir_y_q),
        .step        (speed_q),
        .max         (MAX_Y),
        .override_neg(bus.btn_up),
        .override_pos(bus.btn_down),
        .auto_en     (auto_en),
        .manual_en   (manual_en),
        .next_pos    (next_y),
        .next_dir    (next_dir_y),
        .bounce      (bounce_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_AUTO;
            resume_q <= MODE_AUTO;
        end else begin
            mode_q   <= mode_d;
            resume_q <= resume_d;
        end
    end

    // Select is tested first so it wins over a simultaneous start edge.
    always_comb begin
        mode_d   = mode_q;
        resume_d = resume_q;
        if (frame_tick) begin
            unique case (mode_q)
                MODE_AUTO: begin
                    if (select_edge) begin
                        mode_d   = MODE_PAUSED;
                        resume_d = MODE_AUTO;
                    end else if (start_edge) begin
                        mode_d = MODE_MANUAL;
                    end
                end
                MODE_MANUAL: begin
                    if (select_edge) begin
                        mode_d   = MODE_PAUSED;
                        resume_d = MODE_MANUAL;
                    end else if (start_edge) begin
                        mode_d = MODE_AUTO;
                    end
                end
                MODE_PAUSED: begin
                    if (select_edge) begin
                        mode_d = resume_q;
                    end
                end
                default: mode_d = MODE_AUTO;
            endcase
        end
    end

    // Motion uses mode_q/speed_q, i.e. the values from before this tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_vpos  <= '0;
            frame_tick <= 1'b0;
            btn_prev   <= '0;
            speed_q    <= SPEED_MIN;
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b0;
            left_q     <= 10'(START_X);
            top_q      <= 10'(START_Y);
            color_q    <= '0;
            corner_q   <= 1'b0;
        end else begin
            prev_vpos  <= bus.vpos;
            frame_tick <= (bus.vpos == '0) && (prev_vpos != '0);
            corner_q   <= 1'b0;
            if (frame_tick) begin
                btn_prev <= btn_now;
                left_q   <= next_x;
                top_q    <= next_y;
                dir_x_q  <= next_dir_x;
                dir_y_q  <= next_dir_y;
                if (auto_en) begin
                    color_q  <= color_q + 3'(bounce_x | bounce_y);
                    corner_q <= bounce_x & bounce_y;
                    if (a_edge && !b_edge && speed_q < SPEED_MAX) begin
                        speed_q <= speed_q + 3'd1;
                    end else if (b_edge && !a_edge && speed_q > SPEED_MIN) begin
                        speed_q <= speed_q - 3'd1;
                    end
                end
            end
        end
    end

    assign bus.logo_left   = left_q;
    assign bus.logo_top    = top_q;
    assign bus.color_index = color_q;
    assign bus.mode        = mode_q;
    assign bus.frame_tick  = frame_tick;
    assign bus.corner_hit  = corner_q;

endmodule

// File: tb/tb_logo_motion_scheduler.sv
// tb_logo_motion_scheduler: directed frames with hand-computed expectations
// pushed to a scoreboard; a negedge monitor pops one entry per frame_tick and
// compares the outputs that appear on the following cycle.
`timescale 1ns/1ps
module tb_logo_motion_scheduler;

    localparam logic [7:0] B_NONE  = 8'h00;
    localparam logic [7:0] B_START = 8'h80;
    localparam logic [7:0] B_SEL   = 8'h40;
    localparam logic [7:0] B_A     = 8'h20;
    localparam logic [7:0] B_B     = 8'h10;
    localparam logic [7:0] B_UP    = 8'h08;
    localparam logic [7:0] B_DOWN  = 8'h04;
    localparam logic [7:0] B_LEFT  = 8'h02;
    localparam logic [7:0] B_RIGHT = 8'h01;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
        logic [1:0] m;
        logic       cor;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logo_motion_scheduler_if bus();

    logo_motion_scheduler #(
        .LOGO_SIZE     (128),
        .DISPLAY_WIDTH (640),
        .DISPLAY_HEIGHT(480),
        .START_X       (200),
        .START_Y       (200)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t sb[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;
    int   ticks    = 0;
    int   pushes   = 0;
    logic prev_tick = 1'b0;
    bit   cmp_due   = 1'b0;

    // Speed sweep: buttons per frame and resulting origin.
    logic [7:0] spd_btn [22] = '{B_A, B_A, B_A, B_NONE, B_A, B_NONE, B_A, B_NONE,
                                 B_A, B_NONE, B_A, B_NONE, B_A, B_NONE, B_A, B_NONE,
                                 B_A, B_NONE, B_B, B_NONE, B_A | B_B, B_NONE};
    int spd_x [22] = '{204, 206, 208, 210, 212, 215, 218, 222, 226, 231, 236,
                       242, 248, 255, 262, 269, 276, 283, 290, 296, 302, 308};
    int spd_y [22] = '{196, 194, 192, 190, 188, 185, 182, 178, 174, 169, 164,
                       158, 152, 145, 138, 131, 124, 117, 110, 104, 98, 92};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_due) begin
            cur = sb.pop_front();
            chk("logo_left",   int'(bus.logo_left),   int'(cur.x));
            chk("logo_top",    int'(bus.logo_top),    int'(cur.y));
            chk("color_index", int'(bus.color_index), int'(cur.c));
            chk("mode",        int'(bus.mode),        int'(cur.m));
            chk("corner_hit",  int'(bus.corner_hit),  int'(cur.cor));
            cmp_due = 1'b0;
        end else if (rst_n) begin
            chk("corner_idle", int'(bus.corner_hit), 0);
        end
        if (bus.frame_tick) begin
            ticks++;
            chk("tick_width", int'(prev_tick), 0);
            chk("tick_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) cmp_due = 1'b1;
        end
        prev_tick = bus.frame_tick;
    end

    task automatic set_btns(input logic [7:0] b);
        {bus.btn_start, bus.btn_select, bus.btn_a, bus.btn_b,
         bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b;
    endtask

    task automatic frame(input logic [7:0] b, input int ex, input int ey,
                         input int ec, input int em, input int ecor,
                         input int unsigned zero_cycles);
        exp_t e;
        set_btns(b);
        bus.vpos = 10'd5;
        repeat (2) @(negedge clk);
        bus.vpos = '0;
        e.x = 10'(ex); e.y = 10'(ey); e.c = 3'(ec); e.m = 2'(em); e.cor = 1'(ecor);
        sb.push_back(e);
        pushes++;
        repeat (zero_cycles) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_left"},   int'(bus.logo_left), 200);
        chk({tag, "_top"},    int'(bus.logo_top), 200);
        chk({tag, "_color"},  int'(bus.color_index), 0);
        chk({tag, "_mode"},   int'(bus.mode), 0);
        chk({tag, "_tick"},   int'(bus.frame_tick), 0);
        chk({tag, "_corner"}, int'(bus.corner_hit), 0);
    endtask

    // Reset asserted between clock edges in the middle of a frame.
    task automatic mid_frame_reset();
        set_btns(B_NONE);
        bus.vpos = 10'd5;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b0;
        bus.vpos = '0;
        set_btns(B_NONE);
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_tick_after_release", ticks, 0);

        // Plain AUTO frames.
        frame(B_NONE, 201, 199, 0, 0, 0, 3);
        frame(B_NONE, 202, 198, 0, 0, 0, 3);
        frame(B_NONE, 203, 197, 0, 0, 0, 3);
        chk("three_ticks", ticks, 3);

        // Speed up to saturation, one decrement, simultaneous A+B.
        for (int unsigned i = 0; i < 22; i++)
            frame(spd_btn[i], spd_x[i], spd_y[i], 0, 0, 0, 3);

        mid_frame_reset();

        // Right-edge bounce at speed 3.
        frame(B_A,     201, 199, 0, 0, 0, 3);
        frame(B_NONE,  203, 197, 0, 0, 0, 3);
        frame(B_A,     205, 195, 0, 0, 0, 3);
        frame(B_START, 208, 192, 0, 1, 0, 3);
        for (int unsigned k = 1; k <= 302; k++)
            frame(B_RIGHT, 208 + int'(k), 192, 0, 1, 0, 3);
        frame(B_START, 510, 192, 0, 0, 0, 3);
        frame(B_NONE,  512, 189, 1, 0, 0, 3);
        frame(B_NONE,  509, 186, 1, 0, 0, 3);

        mid_frame_reset();

        // Corner bounce at speed 2.
        frame(B_A,     201, 199, 0, 0, 0, 3);
        frame(B_START, 203, 197, 0, 1, 0, 3);
        for (int unsigned k = 1; k <= 153; k++)
            frame(B_RIGHT | B_DOWN, 203 + int'(k), 197 + int'(k), 0, 1, 0, 3);
        for (int unsigned k = 1; k <= 154; k++)
            frame(B_RIGHT, 356 + int'(k), 350, 0, 1, 0, 3);
        frame(B_START, 510, 350, 0, 0, 0, 3);
        frame(B_DOWN,  512, 352, 1, 0, 1, 3);
        frame(B_NONE,  510, 350, 1, 0, 0, 3);

        mid_frame_reset();

        // MANUAL clamp, pause/resume, select priority.
        frame(B_START, 201, 199, 0, 1, 0, 3);
        for (int unsigned k = 1; k <= 200; k++)
            frame(B_LEFT, 201 - int'(k), 199, 0, 1, 0, 3);
        for (int unsigned k = 0; k < 3; k++)
            frame(B_LEFT, 0, 199, 0, 1, 0, 3);
        frame(B_LEFT | B_RIGHT | B_UP | B_DOWN, 0, 199, 0, 1, 0, 3);
        frame(B_SEL,             0, 199, 0, 2, 0, 3);
        frame(B_RIGHT,           0, 199, 0, 2, 0, 3);
        frame(B_START,           0, 199, 0, 2, 0, 3);
        frame(B_NONE,            0, 199, 0, 2, 0, 3);
        frame(B_SEL,             0, 199, 0, 1, 0, 3);
        frame(B_RIGHT,           1, 199, 0, 1, 0, 3);
        frame(B_START | B_SEL,   1, 199, 0, 2, 0, 3);
        frame(B_NONE,            1, 199, 0, 2, 0, 3);
        frame(B_SEL,             1, 199, 0, 1, 0, 3);
        frame(B_START,           1, 199, 0, 0, 0, 3);
        frame(B_SEL,             2, 198, 0, 2, 0, 3);
        frame(B_NONE,            2, 198, 0, 2, 0, 3);
        frame(B_SEL,             2, 198, 0, 0, 0, 3);

        // vpos parked at 0 for 100 cycles yields a single tick.
        t0 = ticks;
        frame(B_NONE, 3, 197, 0, 0, 0, 100);
        chk("held_vpos_one_tick", ticks - t0, 1);

        bus.vpos = 10'd5;
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("tick_total", ticks, pushes);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
